// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: operation encodings, default latencies and op-class decode.
// Optional multiply-accumulate family is enabled by defining MDU_MADD_EN.
package e_mdu_pkg;

    localparam int MDU_MUL_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF = 10;

    localparam logic [3:0] MDU_none  = 4'd0;
    localparam logic [3:0] MDU_mult  = 4'd1;
    localparam logic [3:0] MDU_multu = 4'd2;
    localparam logic [3:0] MDU_div   = 4'd3;
    localparam logic [3:0] MDU_divu  = 4'd4;
    localparam logic [3:0] MDU_mfhi  = 4'd5;
    localparam logic [3:0] MDU_mflo  = 4'd6;
    localparam logic [3:0] MDU_mthi  = 4'd7;
    localparam logic [3:0] MDU_mtlo  = 4'd8;
    localparam logic [3:0] MDU_madd  = 4'd9;
    localparam logic [3:0] MDU_maddu = 4'd10;
    localparam logic [3:0] MDU_msub  = 4'd11;
    localparam logic [3:0] MDU_msubu = 4'd12;

    // Multiply-latency ops; the madd family only decodes when the feature is built in.
    function automatic logic mdu_is_mul(input logic [3:0] op);
        logic hit;
        hit = (op == MDU_mult) || (op == MDU_multu);
`ifdef MDU_MADD_EN
        hit = hit || (op == MDU_madd) || (op == MDU_maddu) ||
              (op == MDU_msub) || (op == MDU_msubu);
`endif
        return hit;
    endfunction

    function automatic logic mdu_is_div(input logic [3:0] op);
        return (op == MDU_div) || (op == MDU_divu);
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational MDU datapath: 64-bit {HI,LO} result for the given op plus a divide-by-zero flag.
// The madd/maddu/msub/msubu paths exist only when MDU_MADD_EN is defined.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_div_ovf;
    logic        [31:0] w_b_safe;
    logic        [31:0] w_q_s;
    logic        [31:0] w_r_s;
    logic        [31:0] w_q_u;
    logic        [31:0] w_r_u;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Divisor is forced to 1 for the zero and INT_MIN/-1 cases so the dividers never see them.
    assign w_div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign w_b_safe  = ((b == 32'd0) || w_div_ovf) ? 32'd1 : b;

    assign w_q_s = w_div_ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(w_b_safe));
    assign w_r_s = w_div_ovf ? 32'd0         : 32'($signed(a) % $signed(w_b_safe));
    assign w_q_u = a / w_b_safe;
    assign w_r_u = a % w_b_safe;

    always_comb begin
        result   = {hi, lo};
        div_zero = mdu_is_div(op) && (b == 32'd0);
        case (op)
            MDU_mult:  result = w_prod_s;
            MDU_multu: result = w_prod_u;
            MDU_div:   result = {w_r_s, w_q_s};
            MDU_divu:  result = {w_r_u, w_q_u};
`ifdef MDU_MADD_EN
            MDU_madd:  result = {hi, lo} + w_prod_s;
            MDU_maddu: result = {hi, lo} + w_prod_u;
            MDU_msub:  result = {hi, lo} - w_prod_s;
            MDU_msubu: result = {hi, lo} - w_prod_u;
`endif
            default:   result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: HI/LO registers, fixed-latency busy sequencing, mf*/mt* access.
// Define MDU_MADD_EN to add the madd/maddu/msub/msubu accumulate ops.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HILO_out,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_hi_n;
    logic [31:0] r_lo_n;
    logic        r_dz;

    logic [63:0] w_result;
    logic        w_div_zero;
    logic        w_accept;
    logic [3:0]  w_cnt_load;

    e_mdu_calc u_calc (
        .op       (MDOp),
        .a        (A),
        .b        (B),
        .hi       (r_hi),
        .lo       (r_lo),
        .result   (w_result),
        .div_zero (w_div_zero)
    );

    assign w_accept   = (r_state == S_IDLE) && Start && !Req &&
                        (mdu_is_mul(MDOp) || mdu_is_div(MDOp));
    assign w_cnt_load = mdu_is_div(MDOp) ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hi_n  <= 32'd0;
            r_lo_n  <= 32'd0;
            r_dz    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_state <= S_RUN;
                r_cnt   <= w_cnt_load;
                r_hi_n  <= w_result[63:32];
                r_lo_n  <= w_result[31:0];
                r_dz    <= w_div_zero;
            end else if (!Req && MDOp == MDU_mthi) begin
                r_hi <= A;
            end else if (!Req && MDOp == MDU_mtlo) begin
                r_lo <= A;
            end
        end else begin
            // In-flight ops always commit; Req only blocks new work.
            if (r_cnt == 4'd1) begin
                r_state <= S_IDLE;
                r_cnt   <= 4'd0;
                if (!r_dz) begin
                    r_hi <= r_hi_n;
                    r_lo <= r_lo_n;
                end
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign Busy     = (r_state == S_RUN);
    assign HI_out   = r_hi;
    assign LO_out   = r_lo;
    assign HILO_out = (MDOp == MDU_mfhi) ? r_hi :
                      (MDOp == MDU_mflo) ? r_lo : 32'd0;

endmodule
